uart_tx_scheduler: RTL and testbench

//  Arbitrates two byte-stream requesters (register-file read data, 1 byte; ALU result, 2 bytes)

---
 rtl/uart_tx_scheduler_if.sv | 27 ++
 rtl/uart_tx_scheduler.sv | 139 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the byte requesters (RegFile, ALU), the scheduler and UART_TX.
// master is the scheduler's view; slave is the surrounding system's view.
interface uart_tx_scheduler_if #(
    parameter int DATA_WD = 8
);
    logic                   rd_valid;
    logic [DATA_WD-1:0]     rd_data;
    logic                   rd_ready;
    logic                   alu_valid;
    logic [2*DATA_WD-1:0]   alu_data;
    logic                   alu_ready;
    logic                   tx_busy;
    logic [DATA_WD-1:0]     tx_p_data;
    logic                   tx_data_valid;
    logic                   sched_busy;
    logic                   timeout_err;

    modport master (
        input  rd_valid, rd_data, alu_valid, alu_data, tx_busy,
        output rd_ready, alu_ready, tx_p_data, tx_data_valid, sched_busy, timeout_err
    );

    modport slave (
        output rd_valid, rd_data, alu_valid, alu_data, tx_busy,
        input  rd_ready, alu_ready, tx_p_data, tx_data_valid, sched_busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler feeding RegFile bytes and ALU words (low byte first) into UART_TX,
// one Data_Valid pulse per byte, paced by the UART busy handshake with a rise timeout.
module uart_tx_scheduler #(
    parameter int DATA_WD = 8,
    parameter int BUSY_TO = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    uart_tx_scheduler_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    localparam int                CNT_WD   = $clog2(BUSY_TO + 1);
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(BUSY_TO - 1);
    localparam logic [CNT_WD-1:0] CNT_ONE  = CNT_WD'(1);

    state_e               state_q;
    logic                 last_alu_q;
    logic [1:0]           bytes_left_q;
    logic [DATA_WD-1:0]   hold_hi_q;
    logic [CNT_WD-1:0]    to_cnt_q;
    logic [DATA_WD-1:0]   tx_p_data_q;
    logic                 tx_data_valid_q;
    logic                 sched_busy_q;
    logic                 timeout_err_q;

    logic                 grant_rd_s;
    logic                 grant_alu_s;
    logic                 hs_rd_s;
    logic                 hs_alu_s;

    // Round-robin: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant_rd_s  = 1'b0;
        grant_alu_s = 1'b0;
        if (bus.rd_valid && bus.alu_valid) begin
            grant_rd_s  = last_alu_q;
            grant_alu_s = ~last_alu_q;
        end else begin
            grant_rd_s  = bus.rd_valid;
            grant_alu_s = bus.alu_valid;
        end
    end

    assign bus.rd_ready  = (state_q == IDLE) & ~bus.tx_busy & grant_rd_s;
    assign bus.alu_ready = (state_q == IDLE) & ~bus.tx_busy & grant_alu_s;
    assign hs_rd_s       = bus.rd_valid & bus.rd_ready;
    assign hs_alu_s      = bus.alu_valid & bus.alu_ready;

    assign bus.tx_p_data     = tx_p_data_q;
    assign bus.tx_data_valid = tx_data_valid_q;
    assign bus.sched_busy    = sched_busy_q;
    assign bus.timeout_err   = timeout_err_q;

    // Scheduler FSM with registered UART-side outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            last_alu_q      <= 1'b1;
            bytes_left_q    <= 2'd0;
            hold_hi_q       <= {DATA_WD{1'b0}};
            to_cnt_q        <= {CNT_WD{1'b0}};
            tx_p_data_q     <= {DATA_WD{1'b0}};
            tx_data_valid_q <= 1'b0;
            sched_busy_q    <= 1'b0;
            timeout_err_q   <= 1'b0;
        end else begin
            tx_data_valid_q <= 1'b0;
            timeout_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hs_rd_s) begin
                        tx_p_data_q     <= bus.rd_data;
                        hold_hi_q       <= {DATA_WD{1'b0}};
                        bytes_left_q    <= 2'd1;
                        last_alu_q      <= 1'b0;
                        tx_data_valid_q <= 1'b1;
                        sched_busy_q    <= 1'b1;
                        state_q         <= LOAD;
                    end else if (hs_alu_s) begin
                        tx_p_data_q     <= bus.alu_data[DATA_WD-1:0];
                        hold_hi_q       <= bus.alu_data[2*DATA_WD-1:DATA_WD];
                        bytes_left_q    <= 2'd2;
                        last_alu_q      <= 1'b1;
                        tx_data_valid_q <= 1'b1;
                        sched_busy_q    <= 1'b1;
                        state_q         <= LOAD;
                    end else begin
                        sched_busy_q    <= 1'b0;
                    end
                end
                // Entered from IDLE with the pulse already up; from WAIT_LO it raises it here.
                LOAD: begin
                    if (tx_data_valid_q) begin
                        to_cnt_q <= {CNT_WD{1'b0}};
                        state_q  <= WAIT_HI;
                    end else begin
                        tx_data_valid_q <= 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_LO;
                    end else if (to_cnt_q == CNT_LAST) begin
                        timeout_err_q <= 1'b1;
                        bytes_left_q  <= 2'd0;
                        sched_busy_q  <= 1'b0;
                        state_q       <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (!bus.tx_busy) begin
                        bytes_left_q <= bytes_left_q - 2'd1;
                        if (bytes_left_q > 2'd1) begin
                            tx_p_data_q <= hold_hi_q;
                            state_q     <= LOAD;
                        end else begin
                            sched_busy_q <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end else begin
                        state_q <= WAIT_LO;
                    end
                end
                default: begin
                    sched_busy_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: UART busy is driven by hand, every expectation
// is a hand-derived per-cycle value; inputs change and outputs are checked at negedge+1.
module tb_uart_tx_scheduler;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    uart_tx_scheduler_if #(.DATA_WD(8)) bus_if ();

    uart_tx_scheduler #(.DATA_WD(8), .BUSY_TO(4)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    // Called in the cycle where the pulse is expected; walks one UART byte through busy.
    task automatic run_byte(input logic [7:0] exp, input bit last, input string tag);
        check_eq({tag, "_dv"}, 32'(bus_if.tx_data_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(bus_if.tx_p_data), 32'(exp));
        check_eq({tag, "_busy"}, 32'(bus_if.sched_busy), 32'd1);
        @(negedge clk);
        bus_if.tx_busy = 1'b1;
        #1;
        check_eq({tag, "_dv_one"}, 32'(bus_if.tx_data_valid), 32'd0);
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq({tag, "_dv_hold"}, 32'(bus_if.tx_data_valid), 32'd0);
            check_eq({tag, "_data_hold"}, 32'(bus_if.tx_p_data), 32'(exp));
        end
        @(negedge clk);
        bus_if.tx_busy = 1'b0;
        #1;
        check_eq({tag, "_busy_fall0"}, 32'(bus_if.sched_busy), 32'd1);
        @(negedge clk);
        #1;
        if (last) begin
            check_eq({tag, "_busy_fall1"}, 32'(bus_if.sched_busy), 32'd0);
            check_eq({tag, "_dv_end"}, 32'(bus_if.tx_data_valid), 32'd0);
        end else begin
            check_eq({tag, "_gap_busy"}, 32'(bus_if.sched_busy), 32'd1);
            check_eq({tag, "_gap_dv"}, 32'(bus_if.tx_data_valid), 32'd0);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.rd_valid  = 1'b0;
        bus_if.rd_data   = 8'h00;
        bus_if.alu_valid = 1'b0;
        bus_if.alu_data  = 16'h0000;
        bus_if.tx_busy   = 1'b0;

        do_reset();
        check_eq("rst_dv", 32'(bus_if.tx_data_valid), 32'd0);
        check_eq("rst_data", 32'(bus_if.tx_p_data), 32'd0);
        check_eq("rst_busy", 32'(bus_if.sched_busy), 32'd0);
        check_eq("rst_to", 32'(bus_if.timeout_err), 32'd0);
        check_eq("rst_rdy", 32'({bus_if.rd_ready, bus_if.alu_ready}), 32'd0);

        // 1: RegFile only
        @(negedge clk);
        bus_if.rd_valid = 1'b1;
        bus_if.rd_data  = 8'hA3;
        #1;
        check_eq("t1_rd_ready", 32'(bus_if.rd_ready), 32'd1);
        check_eq("t1_alu_ready", 32'(bus_if.alu_ready), 32'd0);
        @(negedge clk);
        #1;
        check_eq("t1_rd_ready_once", 32'(bus_if.rd_ready), 32'd0);
        bus_if.rd_valid = 1'b0;
        run_byte(8'hA3, 1'b1, "t1");
        check_eq("t1_data_kept", 32'(bus_if.tx_p_data), 32'h0000_00A3);

        // 2: ALU only, low byte first
        @(negedge clk);
        bus_if.alu_valid = 1'b1;
        bus_if.alu_data  = 16'hB4D2;
        #1;
        check_eq("t2_alu_ready", 32'(bus_if.alu_ready), 32'd1);
        @(negedge clk);
        #1;
        check_eq("t2_alu_ready_once", 32'(bus_if.alu_ready), 32'd0);
        bus_if.alu_valid = 1'b0;
        run_byte(8'hD2, 1'b0, "t2_lo");
        run_byte(8'hB4, 1'b1, "t2_hi");

        // 3: contention from reset, then strict alternation
        do_reset();
        @(negedge clk);
        bus_if.rd_valid  = 1'b1;
        bus_if.rd_data   = 8'hA3;
        bus_if.alu_valid = 1'b1;
        bus_if.alu_data  = 16'hB4D2;
        #1;
        check_eq("t3_rd_first", 32'(bus_if.rd_ready), 32'd1);
        check_eq("t3_alu_wait", 32'(bus_if.alu_ready), 32'd0);
        @(negedge clk);
        #1;
        check_eq("t3_alu_no_preempt", 32'(bus_if.alu_ready), 32'd0);
        bus_if.rd_valid = 1'b0;
        run_byte(8'hA3, 1'b1, "t3_rd");
        check_eq("t3_alu_turn", 32'(bus_if.alu_ready), 32'd1);
        @(negedge clk);
        #1;
        bus_if.rd_valid = 1'b1;
        bus_if.rd_data  = 8'h5A;
        bus_if.alu_data = 16'h1234;
        run_byte(8'hD2, 1'b0, "t3_alu_lo");
        run_byte(8'hB4, 1'b1, "t3_alu_hi");
        check_eq("t3_alt_rd", 32'(bus_if.rd_ready), 32'd1);
        check_eq("t3_alt_alu", 32'(bus_if.alu_ready), 32'd0);
        @(negedge clk);
        #1;
        bus_if.rd_data = 8'h6B;
        run_byte(8'h5A, 1'b1, "t3_rd2");
        check_eq("t3_alt2_alu", 32'(bus_if.alu_ready), 32'd1);
        check_eq("t3_alt2_rd", 32'(bus_if.rd_ready), 32'd0);
        @(negedge clk);
        #1;
        bus_if.rd_valid  = 1'b0;
        bus_if.alu_valid = 1'b0;
        run_byte(8'h34, 1'b0, "t3_alu2_lo");
        run_byte(8'h12, 1'b1, "t3_alu2_hi");

        // 4: UART busy blocks the grant
        @(negedge clk);
        bus_if.tx_busy  = 1'b1;
        bus_if.rd_valid = 1'b1;
        bus_if.rd_data  = 8'h3C;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_no_ready", 32'(bus_if.rd_ready), 32'd0);
            check_eq("t4_no_dv", 32'(bus_if.tx_data_valid), 32'd0);
            @(negedge clk);
            #1;
        end
        bus_if.tx_busy = 1'b0;
        #1;
        check_eq("t4_ready", 32'(bus_if.rd_ready), 32'd1);
        @(negedge clk);
        #1;
        bus_if.rd_valid = 1'b0;
        run_byte(8'h3C, 1'b1, "t4");

        // 5: busy never rises -> timeout, high byte dropped
        @(negedge clk);
        bus_if.alu_valid = 1'b1;
        bus_if.alu_data  = 16'hC3E1;
        #1;
        check_eq("t5_alu_ready", 32'(bus_if.alu_ready), 32'd1);
        @(negedge clk);
        #1;
        bus_if.alu_valid = 1'b0;
        check_eq("t5_dv", 32'(bus_if.tx_data_valid), 32'd1);
        check_eq("t5_data", 32'(bus_if.tx_p_data), 32'h0000_00E1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_eq("t5_to_early", 32'(bus_if.timeout_err), 32'd0);
            check_eq("t5_busy_wait", 32'(bus_if.sched_busy), 32'd1);
        end
        @(negedge clk);
        #1;
        check_eq("t5_to_pulse", 32'(bus_if.timeout_err), 32'd1);
        check_eq("t5_idle", 32'(bus_if.sched_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("t5_to_once", 32'(bus_if.timeout_err), 32'd0);
            check_eq("t5_no_hi", 32'(bus_if.tx_data_valid), 32'd0);
            check_eq("t5_data_kept", 32'(bus_if.tx_p_data), 32'h0000_00E1);
        end

        // 6: reset in WAIT_LO of the ALU low byte
        @(negedge clk);
        bus_if.alu_valid = 1'b1;
        bus_if.alu_data  = 16'h7F01;
        #1;
        check_eq("t6_alu_ready", 32'(bus_if.alu_ready), 32'd1);
        @(negedge clk);
        #1;
        bus_if.alu_valid = 1'b0;
        check_eq("t6_dv", 32'(bus_if.tx_data_valid), 32'd1);
        check_eq("t6_data", 32'(bus_if.tx_p_data), 32'h0000_0001);
        @(negedge clk);
        bus_if.tx_busy = 1'b1;
        @(negedge clk);
        #1;
        check_eq("t6_in_frame", 32'(bus_if.sched_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_dv", 32'(bus_if.tx_data_valid), 32'd0);
        check_eq("t6_rst_data", 32'(bus_if.tx_p_data), 32'd0);
        check_eq("t6_rst_busy", 32'(bus_if.sched_busy), 32'd0);
        check_eq("t6_rst_to", 32'(bus_if.timeout_err), 32'd0);
        bus_if.tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_eq("t6_no_hi", 32'(bus_if.tx_data_valid), 32'd0);
            check_eq("t6_idle", 32'(bus_if.sched_busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
